// File: rtl/zircon_tlc549_pkg.sv
// rtl/zircon_tlc549_pkg.sv - shared constants and FSM encoding for the TLC549 reader
package zircon_tlc549_pkg;

    // Avalon word addresses
    localparam logic ADDR_CTRL = 1'b0;
    localparam logic ADDR_DATA = 1'b1;

    // CTRL write bits
    localparam int CTRL_START = 0;
    localparam int CTRL_CONT  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        CONV  = 2'd3
    } state_t;

endpackage

// File: rtl/zircon_avalon_tlc549_logic.sv
// rtl/zircon_avalon_tlc549_logic.sv - TLC549 frame sequencer, pin drivers and shift register
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   start        one-cycle request to run a frame (ignored unless idle)
//   cont         continuous mode level; chains frames and leaves IDLE by itself
//   adc_data     raw serial data pin from the ADC
//   busy         high in every state but IDLE
//   done         one-cycle pulse on the clock edge that enters CONV
//   first_frame  high until the first frame since reset has completed
//   result       shift register contents; complete while done is high
//   cs, sclk     registered ADC chip select (active low) and I/O clock
module zircon_avalon_tlc549_logic #(
    parameter int CLK_DIV = 25,
    parameter int T_CS_SU = 75,
    parameter int T_CONV  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       adc_data,
    output logic       busy,
    output logic       done,
    output logic       first_frame,
    output logic [7:0] result,
    output logic       cs,
    output logic       sclk
);
    import zircon_tlc549_pkg::*;

    localparam int MAX_P = (T_CONV > T_CS_SU) ? ((T_CONV > CLK_DIV) ? T_CONV : CLK_DIV)
                                              : ((T_CS_SU > CLK_DIV) ? T_CS_SU : CLK_DIV);
    localparam int CNT_W = $clog2(MAX_P);
    // The first low phase of SHIFT is part of the CS-to-first-rise setup time,
    // so SETUP only covers the remainder.
    localparam int SETUP_CYC = T_CS_SU - CLK_DIV;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               cs_q, cs_d;
    logic               sclk_q, sclk_d;
    logic [1:0]         sync_q, sync_d;
    logic               first_q, first_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            sync_q  <= '0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            sync_q  <= sync_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        sync_d  = {sync_q[0], adc_data};
        first_d = first_q;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start || cont) begin
                    state_d = SETUP;
                    cs_d    = 1'b0;
                    bit_d   = '0;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        // Rising edge of the I/O clock: capture the synchronised bit.
                        sclk_d  = 1'b1;
                        shreg_d = {shreg_q[6:0], sync_q[1]};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            state_d = CONV;
                            cs_d    = 1'b1;
                            done    = 1'b1;
                            first_d = 1'b0;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
            end
            CONV: begin
                if (cnt_q == CNT_W'(T_CONV - 1)) begin
                    cnt_d = '0;
                    if (cont) begin
                        state_d = SETUP;
                        cs_d    = 1'b0;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign first_frame = first_q;
    assign result      = shreg_q;
    assign cs          = cs_q;
    assign sclk        = sclk_q;

endmodule

// File: rtl/zircon_avalon_tlc549.sv
// rtl/zircon_avalon_tlc549.sv - Avalon-MM slave reading the TLC549 serial ADC
//
// Ports:
//   csi_clk, rsi_reset      system clock, asynchronous active-high reset
//   avs_address             0 = CTRL/STATUS, 1 = DATA
//   avs_write/avs_writedata CTRL write: bit0 START pulse, bit1 CONT level
//   avs_read/avs_readdata   read latency 1; CTRL = {primed, valid, busy}, DATA = result
//   coe_tlc549_cs/clk/data  ADC chip select (active low), I/O clock, serial data in
module zircon_avalon_tlc549 #(
    parameter int CLK_DIV = 25,
    parameter int T_CS_SU = 75,
    parameter int T_CONV  = 1000
) (
    input  logic        csi_clk,
    input  logic        rsi_reset,
    input  logic        avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        coe_tlc549_cs,
    output logic        coe_tlc549_clk,
    input  logic        coe_tlc549_data
);
    import zircon_tlc549_pkg::*;

    logic        cont_q, cont_d;
    logic        valid_q, valid_d;
    logic        primed_q, primed_d;
    logic [7:0]  result_q, result_d;
    logic [31:0] readdata_q, readdata_d;

    logic        ctrl_wr, start, busy, frame_done, first_frame;
    logic [7:0]  frame_result;
    logic        unused_wdata;

    assign ctrl_wr      = avs_write && (avs_address == ADDR_CTRL);
    assign start        = ctrl_wr && avs_writedata[CTRL_START];
    assign unused_wdata = ^avs_writedata[31:2];

    zircon_avalon_tlc549_logic #(
        .CLK_DIV (CLK_DIV),
        .T_CS_SU (T_CS_SU),
        .T_CONV  (T_CONV)
    ) u_logic (
        .clk         (csi_clk),
        .rst         (rsi_reset),
        .start       (start),
        .cont        (cont_q),
        .adc_data    (coe_tlc549_data),
        .busy        (busy),
        .done        (frame_done),
        .first_frame (first_frame),
        .result      (frame_result),
        .cs          (coe_tlc549_cs),
        .sclk        (coe_tlc549_clk)
    );

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            cont_q     <= 1'b0;
            valid_q    <= 1'b0;
            primed_q   <= 1'b0;
            result_q   <= '0;
            readdata_q <= '0;
        end else begin
            cont_q     <= cont_d;
            valid_q    <= valid_d;
            primed_q   <= primed_d;
            result_q   <= result_d;
            readdata_q <= readdata_d;
        end
    end

    always_comb begin
        cont_d     = cont_q;
        valid_d    = valid_q;
        primed_d   = primed_q;
        result_d   = result_q;
        readdata_d = '0;

        if (ctrl_wr) begin
            cont_d = avs_writedata[CTRL_CONT];
        end

        if (avs_read) begin
            if (avs_address == ADDR_CTRL) begin
                readdata_d = {29'b0, primed_q, valid_q, busy};
            end else begin
                readdata_d = {24'b0, result_q};
                valid_d    = 1'b0;
            end
        end

        // The first frame after reset carries the ADC's stale conversion.
        // A store in the same cycle as a DATA read overrides the clear.
        if (frame_done) begin
            primed_d = 1'b1;
            if (!first_frame) begin
                result_d = frame_result;
                valid_d  = 1'b1;
            end
        end
    end

    assign avs_readdata = readdata_q;

endmodule

// File: tb/tb_zircon_avalon_tlc549.sv
// tb/tb_zircon_avalon_tlc549.sv - self-checking bench for zircon_avalon_tlc549
module tb_zircon_avalon_tlc549;

    localparam int CLK_DIV = 25;
    localparam int T_CS_SU = 75;
    localparam int T_CONV  = 1000;

    logic        csi_clk = 1'b0;
    logic        rsi_reset = 1'b1;
    logic        avs_address = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        coe_tlc549_cs;
    logic        coe_tlc549_clk;
    logic        coe_tlc549_data;

    always #10 csi_clk = ~csi_clk;

    zircon_avalon_tlc549 #(
        .CLK_DIV (CLK_DIV),
        .T_CS_SU (T_CS_SU),
        .T_CONV  (T_CONV)
    ) dut (
        .csi_clk         (csi_clk),
        .rsi_reset       (rsi_reset),
        .avs_address     (avs_address),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_read        (avs_read),
        .avs_readdata    (avs_readdata),
        .coe_tlc549_cs   (coe_tlc549_cs),
        .coe_tlc549_clk  (coe_tlc549_clk),
        .coe_tlc549_data (coe_tlc549_data)
    );

    int checks = 0;
    int failures = 0;

    // ADC model: next byte presented when CS falls, MSB first, advances on each I/O-clock fall.
    logic [7:0] adc_q[$];
    logic [7:0] cur_byte = 8'h00;
    logic [2:0] adc_bit = 3'd0;

    always @(negedge coe_tlc549_cs) begin
        if (adc_q.size() > 0) cur_byte = adc_q.pop_front();
        else cur_byte = 8'h00;
        adc_bit = 3'd0;
    end

    always @(negedge coe_tlc549_clk) begin
        if (!coe_tlc549_cs) adc_bit = adc_bit + 3'd1;
    end

    assign coe_tlc549_data = coe_tlc549_cs ? 1'b0 : cur_byte[3'd7 - adc_bit];

    // Pin monitor plus register-level model: a completed frame (CS rising) stores the
    // byte the ADC sent, unless it is the first frame since reset.
    int cyc = 0, falls_total = 0, ends_total = 0, rises_total = 0, rises_frame = 0;
    int first_rise_dly = 0, bad_period = 0, last_rise = 0, fall_cyc = 0;
    int rise_cs_cyc = 0, last_gap = 0;
    logic prev_cs = 1'b1, prev_clk = 1'b0;
    logic model_primed = 1'b0, model_valid = 1'b0;
    logic [7:0] model_result = 8'h00;

    always @(negedge csi_clk) begin
        cyc++;
        if (rsi_reset) begin
            model_primed = 1'b0;
            model_valid  = 1'b0;
            model_result = 8'h00;
            rises_frame  = 0;
        end else begin
            if (prev_cs && !coe_tlc549_cs) begin
                falls_total++;
                last_gap    = cyc - rise_cs_cyc;
                fall_cyc    = cyc;
                rises_frame = 0;
                bad_period  = 0;
            end
            if (!prev_clk && coe_tlc549_clk) begin
                rises_total++;
                rises_frame++;
                if (rises_frame == 1) first_rise_dly = cyc - fall_cyc;
                else if (cyc - last_rise != 2 * CLK_DIV) bad_period++;
                last_rise = cyc;
            end
            if (!prev_cs && coe_tlc549_cs) begin
                ends_total++;
                rise_cs_cyc = cyc;
                if (model_primed) begin
                    model_result = cur_byte;
                    model_valid  = 1'b1;
                end
                model_primed = 1'b1;
            end
        end
        prev_cs  = coe_tlc549_cs;
        prev_clk = coe_tlc549_clk;
    end

    function automatic logic [31:0] model_ctrl(input logic busy);
        return {29'b0, model_primed, model_valid, busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic a, input logic [31:0] d);
        @(negedge csi_clk); #1;
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge csi_clk); #1;
        avs_write     = 1'b0;
        avs_writedata = '0;
    endtask

    task automatic bus_read(input logic a, output logic [31:0] d);
        @(negedge csi_clk); #1;
        avs_address = a;
        avs_read    = 1'b1;
        if (a) model_valid = 1'b0;
        @(negedge csi_clk); #1;
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic read_chk(input string name, input logic a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(name, d, exp);
    endtask

    // which: 0 = CS falls, 1 = frame ends (CS rises)
    task automatic wait_evt(input int which, input int want, input int budget);
        int n = 0;
        while (((which == 0) ? falls_total : ends_total) < want && n < budget) begin
            @(negedge csi_clk); #1;
            n++;
        end
        if (((which == 0) ? falls_total : ends_total) < want) begin
            checks++;
            failures++;
            $display("FAIL timeout_evt%0d actual=%0d required=%0d", which,
                     (which == 0) ? falls_total : ends_total, want);
        end
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] d;
        int n = 0;
        d = 32'h1;
        while (d[0] && n < budget) begin
            bus_read(1'b0, d);
            n++;
        end
        if (d[0]) begin
            checks++;
            failures++;
            $display("FAIL timeout_idle actual=busy required=idle");
        end
    endtask

    task automatic do_reset();
        @(negedge csi_clk); #1;
        rsi_reset = 1'b1;
        adc_q.delete();
        repeat (3) @(negedge csi_clk);
        #1;
        rsi_reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  v1;
        logic [7:0]  v2;
        logic [31:0] ctrl_a;
        logic [31:0] ctrl_b;
        logic [31:0] data;
        logic [31:0] ctrl_c;
    } vec_t;

    task automatic run_pair(input vec_t v, input bit timing);
        adc_q.push_back(v.v1);
        adc_q.push_back(v.v2);
        bus_write(1'b0, 32'h1);
        wait_idle(2000);
        if (timing) begin
            chk("cs_to_first_rise", 32'(first_rise_dly), 32'(T_CS_SU));
            chk("rises_per_frame", 32'(rises_frame), 32'd8);
            chk("bad_periods", 32'(bad_period), 32'd0);
        end
        read_chk("ctrl_after_f1", 1'b0, v.ctrl_a);
        bus_write(1'b0, 32'h1);
        wait_idle(2000);
        read_chk("ctrl_after_f2", 1'b0, v.ctrl_b);
        read_chk("data_after_f2", 1'b1, v.data);
        read_chk("ctrl_after_read", 1'b0, v.ctrl_c);
    endtask

    initial begin
        #2500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        vec_t vecs[3];
        logic [7:0] vals[$];
        logic [31:0] d;
        logic [7:0] v_old, v_new;
        int f0, e0, r0, n;

        vecs[0] = '{8'h5A, 8'hA5, 32'h4, 32'h6, 32'hA5, 32'h4};
        vecs[1] = '{8'h00, 8'hFF, 32'h4, 32'h6, 32'hFF, 32'h4};
        vecs[2] = '{8'hFF, 8'h01, 32'h4, 32'h6, 32'h01, 32'h4};

        // Reset state
        repeat (3) @(negedge csi_clk);
        #1 rsi_reset = 1'b0;
        chk("reset_cs", 32'(coe_tlc549_cs), 32'd1);
        chk("reset_clk", 32'(coe_tlc549_clk), 32'd0);
        chk("reset_readdata", avs_readdata, 32'h0);
        read_chk("reset_ctrl", 1'b0, 32'h0);
        read_chk("reset_data", 1'b1, 32'h0);

        // Single-shot pairs: first frame discarded, second stored
        for (int i = 0; i < 3; i++) begin
            do_reset();
            run_pair(vecs[i], i == 0);
        end

        // Continuous mode: fixed then random frame sequences
        for (int run = 0; run < 2; run++) begin
            do_reset();
            vals.delete();
            if (run == 0) begin
                vals.push_back(8'h00); vals.push_back(8'hFF); vals.push_back(8'h81);
            end else begin
                for (int k = 0; k < 4; k++) vals.push_back(8'($urandom_range(0, 255)));
            end
            foreach (vals[k]) adc_q.push_back(vals[k]);
            n  = vals.size();
            f0 = falls_total;
            e0 = ends_total;
            bus_write(1'b0, 32'h2);
            for (int k = 0; k < n; k++) begin
                wait_evt(0, f0 + k + 1, 3000);
                if (k > 0) chk("cont_cs_high", 32'(last_gap), 32'(T_CONV));
                if (k == n - 1) bus_write(1'b0, 32'h0);
                wait_evt(1, e0 + k + 1, 1000);
                read_chk("cont_ctrl", 1'b0, model_ctrl(1'b1));
                if (k > 0) read_chk("cont_data", 1'b1, {24'b0, vals[k]});
            end
            wait_idle(2000);
            chk("cont_frames", 32'(falls_total - f0), 32'(n));
            read_chk("cont_idle_ctrl", 1'b0, 32'h4);
        end

        // START while busy is ignored; DATA read colliding with a store
        do_reset();
        v_old = 8'($urandom_range(0, 255));
        v_new = ~v_old;
        adc_q.push_back(8'h33); adc_q.push_back(v_old); adc_q.push_back(v_new);
        r0 = rises_total;
        f0 = falls_total;
        bus_write(1'b0, 32'h1);
        wait_evt(0, f0 + 1, 200);
        repeat (100) @(negedge csi_clk);
        bus_write(1'b0, 32'h1);
        wait_evt(1, ends_total + 1, 1000);
        repeat (200) @(negedge csi_clk);
        bus_write(1'b0, 32'h1);
        wait_idle(2000);
        chk("busy_start_rises", 32'(rises_total - r0), 32'd8);
        chk("busy_start_frames", 32'(falls_total - f0), 32'd1);
        bus_write(1'b0, 32'h1);
        wait_idle(2000);
        bus_write(1'b0, 32'h1);
        wait_evt(0, f0 + 3, 200);
        repeat (T_CS_SU - CLK_DIV + 16 * CLK_DIV - 2) @(negedge csi_clk);
        read_chk("collide_old_data", 1'b1, {24'b0, v_old});
        chk("collide_align", 32'(rise_cs_cyc), 32'(cyc));
        read_chk("collide_ctrl", 1'b0, 32'h7);
        read_chk("collide_new_data", 1'b1, {24'b0, v_new});
        wait_idle(2000);

        // Reset during SHIFT bit 4
        do_reset();
        adc_q.push_back(8'h3C);
        f0 = falls_total;
        bus_write(1'b0, 32'h1);
        wait_evt(0, f0 + 1, 200);
        n = 0;
        while (rises_frame < 4 && n < 1000) begin
            @(negedge csi_clk); #1;
            n++;
        end
        chk("reached_bit4", 32'(rises_frame), 32'd4);
        repeat (10) @(negedge csi_clk);
        #3 rsi_reset = 1'b1;
        #1;
        chk("abort_cs", 32'(coe_tlc549_cs), 32'd1);
        chk("abort_clk", 32'(coe_tlc549_clk), 32'd0);
        repeat (2) @(negedge csi_clk);
        #1 rsi_reset = 1'b0;
        read_chk("abort_ctrl", 1'b0, 32'h0);
        read_chk("abort_data", 1'b1, 32'h0);
        run_pair(vecs[0], 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
